// File: rtl/gcd_pkg.sv
// Shared types and helpers for the parametrised GCD engine: controller states,
// datapath operation codes and the width of the power-of-two shift register k.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SHIFT,
    DONE
  } state_e;

  // One operation per cycle, chosen by the controller and executed by the datapath.
  typedef enum logic [3:0] {
    OP_NONE,
    OP_LOAD,
    OP_SUB_A,
    OP_SUB_B,
    OP_SUBH_A,
    OP_SUBH_B,
    OP_HALVE_BOTH,
    OP_HALVE_A,
    OP_HALVE_B,
    OP_RES_A,
    OP_RES_B,
    OP_RES_SHIFT
  } op_e;

  localparam int ALGO_SUB   = 0;
  localparam int ALGO_STEIN = 1;

  // k counts common factors of two, so it never exceeds WIDTH.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/gcd_ctrl_fsm.sv
// GCD controller: sequences IDLE/CALC/SHIFT/DONE, picks the datapath operation
// from the comparator flags, drives busy/done and the saturating iteration count.
module gcd_ctrl_fsm
  import gcd_pkg::*;
#(
  parameter int ALGO  = ALGO_SUB,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             eq_i,
  input  logic             gt_i,
  input  logic             a_even_i,
  input  logic             b_even_i,
  input  logic             a_zero_i,
  input  logic             b_zero_i,
  output op_e              op_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] iter_count_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = CALC;
      CALC: begin
        if (a_zero_i || b_zero_i) begin
          state_d = DONE;
        end else if (ALGO == ALGO_STEIN) begin
          if (!a_even_i && !b_even_i && eq_i) state_d = SHIFT;
        end else if (eq_i) begin
          state_d = DONE;
        end
      end
      SHIFT: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_o = OP_NONE;
    unique case (state_q)
      IDLE: if (start_i) op_o = OP_LOAD;
      CALC: begin
        if (a_zero_i)      op_o = OP_RES_B;
        else if (b_zero_i) op_o = OP_RES_A;
        else if (ALGO == ALGO_STEIN) begin
          if (a_even_i && b_even_i) op_o = OP_HALVE_BOTH;
          else if (a_even_i)        op_o = OP_HALVE_A;
          else if (b_even_i)        op_o = OP_HALVE_B;
          else if (eq_i)            op_o = OP_NONE;
          else if (gt_i)            op_o = OP_SUBH_A;
          else                      op_o = OP_SUBH_B;
        end else begin
          if (eq_i)      op_o = OP_RES_A;
          else if (gt_i) op_o = OP_SUB_A;
          else           op_o = OP_SUB_B;
        end
      end
      SHIFT:   op_o = OP_RES_SHIFT;
      default: op_o = OP_NONE;
    endcase
  end

  assign busy_o       = (state_q == CALC) || (state_q == SHIFT);
  assign done_o       = (state_q == DONE);
  assign iter_count_o = iter_q;

  // Held from the end of an op until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      iter_q <= '0;
    end else if (busy_o && iter_q != {CNT_W{1'b1}}) begin
      iter_q <= iter_q + 1'b1;
    end
  end

endmodule

// File: rtl/gcd_engine_p.sv
// Parametrised GCD engine: operand/result datapath plus the controller.
// ALGO selects subtractive Euclid or binary (Stein) at elaboration time.
module gcd_engine_p
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ALGO  = ALGO_SUB,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iter_count
);

  localparam int KW = k_width(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] diff_ab, diff_ba;
  logic             eq, gt, a_even, b_even, a_zero, b_zero;
  op_e              op;

  assign eq      = (a_q == b_q);
  assign gt      = (a_q > b_q);
  assign a_even  = ~a_q[0];
  assign b_even  = ~b_q[0];
  assign a_zero  = (a_q == '0);
  assign b_zero  = (b_q == '0);
  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;

  gcd_ctrl_fsm #(
    .ALGO  (ALGO),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .eq_i         (eq),
    .gt_i         (gt),
    .a_even_i     (a_even),
    .b_even_i     (b_even),
    .a_zero_i     (a_zero),
    .b_zero_i     (b_zero),
    .op_o         (op),
    .busy_o       (busy),
    .done_o       (done),
    .iter_count_o (iter_count)
  );

  // Subtractions only fire on the larger operand, so they never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      unique case (op)
        OP_LOAD: begin
          a_q <= a_in;
          b_q <= b_in;
          k_q <= '0;
        end
        OP_SUB_A:  a_q <= diff_ab;
        OP_SUB_B:  b_q <= diff_ba;
        OP_SUBH_A: a_q <= diff_ab >> 1;
        OP_SUBH_B: b_q <= diff_ba >> 1;
        OP_HALVE_BOTH: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          k_q <= k_q + 1'b1;
        end
        OP_HALVE_A:   a_q      <= a_q >> 1;
        OP_HALVE_B:   b_q      <= b_q >> 1;
        OP_RES_A:     result_q <= a_q;
        OP_RES_B:     result_q <= b_q;
        OP_RES_SHIFT: result_q <= a_q << k_q;
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_gcd_engine_p.sv
// Directed bench for gcd_engine_p: Euclid and Stein instances at WIDTH=16 plus
// a narrow Euclid instance for counter saturation, all on one clock and reset.
module tb_gcd_engine_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s = 1'b0, start_t = 1'b0, start_8 = 1'b0;
  logic [15:0] a_s = '0, b_s = '0, a_t = '0, b_t = '0;
  logic [7:0]  a_8 = '0, b_8 = '0;
  logic        busy_s, busy_t, busy_8, done_s, done_t, done_8;
  logic [15:0] res_s, res_t, it_s, it_t;
  logic [7:0]  res_8, it_8;

  gcd_engine_p #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u_sub (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a_in(a_s), .b_in(b_s),
    .busy(busy_s), .done(done_s), .result(res_s), .iter_count(it_s));

  gcd_engine_p #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u_stn (
    .clk(clk), .rst_n(rst_n), .start(start_t), .a_in(a_t), .b_in(b_t),
    .busy(busy_t), .done(done_t), .result(res_t), .iter_count(it_t));

  gcd_engine_p #(.WIDTH(8), .ALGO(0), .CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_8), .a_in(a_8), .b_in(b_8),
    .busy(busy_8), .done(done_8), .result(res_8), .iter_count(it_8));

  logic [2:0]  done_v, busy_v;
  logic [31:0] res_v [3];
  logic [31:0] it_v  [3];
  assign done_v   = {done_8, done_t, done_s};
  assign busy_v   = {busy_8, busy_t, busy_s};
  assign res_v[0] = 32'(res_s);
  assign res_v[1] = 32'(res_t);
  assign res_v[2] = 32'(res_8);
  assign it_v[0]  = 32'(it_s);
  assign it_v[1]  = 32'(it_t);
  assign it_v[2]  = 32'(it_8);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one unit after the start edge.
  task automatic go(input int sel, input logic [15:0] a, input logic [15:0] b);
    case (sel)
      0: begin a_s = a; b_s = b; start_s = 1'b1; end
      1: begin a_t = a; b_t = b; start_t = 1'b1; end
      default: begin a_8 = a[7:0]; b_8 = b[7:0]; start_8 = 1'b1; end
    endcase
    @(posedge clk); #1;
    start_s = 1'b0; start_t = 1'b0; start_8 = 1'b0;
  endtask

  // Counts edges until done is seen; nbusy counts busy samples before done.
  task automatic wait_done(input int sel, input int budget, input string tag,
                           output int cyc, output int nbusy);
    bit ok = 1'b0;
    cyc = 0;
    nbusy = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done_v[sel]) begin
        ok = 1'b1;
        break;
      end
      if (busy_v[sel]) nbusy++;
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
  } zvec_t;

  initial begin
    int    cyc, nb, ndone;
    zvec_t zv [3];
    zv[0] = '{16'd0,  16'd42, 16'd42};
    zv[1] = '{16'd42, 16'd0,  16'd42};
    zv[2] = '{16'd0,  16'd0,  16'd0};

    // Reset state
    #12;
    check("rst_busy", 32'(busy_s), 0);
    check("rst_done", 32'(done_s), 0);
    check("rst_result", res_v[0], 0);
    check("rst_iter", it_v[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Euclid 26,39: b=13, a=13, equal -> 3 CALC cycles
    go(0, 16'd26, 16'd39);
    check("sub_busy_after_start", 32'(busy_s), 1);
    wait_done(0, 50, "sub_26_39", cyc, nb);
    check("sub_latency", cyc, 3);
    check("sub_busy_cycles", nb, 2);
    check("sub_busy_in_done", 32'(busy_s), 0);
    check("sub_result", res_v[0], 13);
    check("sub_iter", it_v[0], 3);
    @(posedge clk); #1;
    check("sub_done_one_cycle", 32'(done_s), 0);
    repeat (3) @(posedge clk);
    #1;
    check("sub_result_held", res_v[0], 13);
    check("sub_iter_held", it_v[0], 3);

    // Stein 48,180: k=2, odd parts 3 and 45 -> 3, then 3<<2 = 12 after 9 cycles
    go(1, 16'd48, 16'd180);
    wait_done(1, 40, "stn_48_180", cyc, nb);
    check("stn_48_180_latency", cyc, 9);
    check("stn_48_180_result", res_v[1], 12);
    check("stn_48_180_iter", it_v[1], 9);
    @(posedge clk); #1;

    // Stein 26,39: a=13, b=(39-13)/2=13, equal, shift -> 4 cycles
    go(1, 16'd26, 16'd39);
    wait_done(1, 40, "stn_26_39", cyc, nb);
    check("stn_26_39_result", res_v[1], 13);
    check("stn_26_39_iter", it_v[1], 4);
    @(posedge clk); #1;

    // Zero operands on both algorithms
    for (int s = 0; s < 2; s++) begin
      for (int z = 0; z < 3; z++) begin
        go(s, zv[z].a, zv[z].b);
        wait_done(s, 10, "zero", cyc, nb);
        check($sformatf("zero_lat_s%0d_v%0d", s, z), cyc, 1);
        check($sformatf("zero_res_s%0d_v%0d", s, z), res_v[s], 32'(zv[z].g));
        check($sformatf("zero_iter_s%0d_v%0d", s, z), it_v[s], 1);
        @(posedge clk); #1;
      end
    end

    // Narrow counter: 254 subtractions plus the equality cycle = 255
    go(2, 16'd255, 16'd1);
    wait_done(2, 400, "sat", cyc, nb);
    check("sat_result", res_v[2], 1);
    check("sat_iter", it_v[2], 255);
    check("sat_latency", cyc, 255);
    @(posedge clk); #1;

    // start held high: one op every 5 edges, each ending in a single done pulse
    a_s = 16'd26; b_s = 16'd39; start_s = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_s) ndone++;
      if (i == 3) check("hold_done_at_3", 32'(done_s), 1);
      if (i == 4) check("hold_idle_at_4", 32'(busy_s | done_s), 0);
      if (i == 5) check("hold_restart_at_5", 32'(busy_s), 1);
    end
    start_s = 1'b0;
    check("hold_done_count", ndone, 2);
    check("hold_result", res_v[0], 13);
    @(posedge clk); #1;
    check("hold_back_idle", 32'(busy_s), 0);

    // start with new operands mid-CALC is ignored
    go(0, 16'd26, 16'd39);
    a_s = 16'd100; b_s = 16'd7; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    wait_done(0, 50, "midstart", cyc, nb);
    check("midstart_latency", cyc, 2);
    check("midstart_result", res_v[0], 13);
    check("midstart_iter", it_v[0], 3);
    @(posedge clk); #1;
    check("midstart_no_reop", 32'(busy_s), 0);

    // Asynchronous reset mid-CALC
    go(0, 16'd26, 16'd39);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_s), 0);
    check("arst_done", 32'(done_s), 0);
    check("arst_result", res_v[0], 0);
    check("arst_iter", it_v[0], 0);
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done_s) ndone++;
    end
    check("arst_no_done", ndone, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    go(0, 16'd26, 16'd39);
    wait_done(0, 50, "post_rst", cyc, nb);
    check("post_rst_result", res_v[0], 13);
    check("post_rst_iter", it_v[0], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
